// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the 8N1 serial receiver: baud divisors for a
// 12 MHz clock, the receiver FSM state encoding and a counter-width helper.
package uart_rx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rxState_e;

    // Narrowest down-counter width that can hold BAUD-1.
    function automatic int cntWidth(input int baud);
        return (baud <= 2) ? 1 : $clog2(baud);
    endfunction

endpackage

// File: rtl/baudgen_rx.sv
// Loadable bit-period down-counter for the receiver. A half-period load centres
// the start-bit sample, so every later full-period reload lands mid-bit.
module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int W = cntWidth(BAUD);
    localparam logic [W-1:0] FULL_LOAD = W'(BAUD - 1);
    localparam logic [W-1:0] HALF_LOAD = W'(BAUD / 2 - 1);

    logic [W-1:0] cnt_q;

    // Loading N-1 makes tick appear exactly N edges after the load edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= half ? HALF_LOAD : FULL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver with a 2-FF input synchronizer and break handling.
// Optional stop-bit framing check: define UART_RX_FRAMING_CHECK_EN.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       busy
);

    logic [1:0] sync_q;
    logic       rxS;
    rxState_e   state_q;
    logic [2:0] bitIdx_q;
    logic [7:0] shreg_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       busy_q;
    logic       tick;
    logic       load;
    logic       half;
`ifdef UART_RX_FRAMING_CHECK_EN
    logic       ferr_q;
`endif

    // Resetting to 1 keeps a reset release from looking like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxS  = sync_q[1];
    assign half = (state_q == IDLE);
    assign load = (state_q == IDLE) ? ~rxS : (tick && (state_q != BREAK));

    baudgen_rx #(
        .BAUD (BAUD)
    ) u_baudgen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .half (half),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitIdx_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
            ferr_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
            ferr_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rxS) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxS) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q  <= DATA;
                            bitIdx_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_q <= {rxS, shreg_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rxS) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
`ifdef UART_RX_FRAMING_CHECK_EN
                            ferr_q  <= 1'b1;
`else
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
`endif
                            state_q <= BREAK;
                        end
                    end
                end
                // A held-low line stays here so a break never yields repeated bytes.
                BREAK: begin
                    if (rxS) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;
`ifdef UART_RX_FRAMING_CHECK_EN
    assign ferr  = ferr_q;
`else
    assign ferr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (BAUD=8 and BAUD=104), directed frames
// whose expected strobes (kind, byte, exact cycle) are queued and popped by monitors.
module tb_uart_rx;

    localparam int BAUD_A = 8;
    localparam int BAUD_B = 104;
`ifdef UART_RX_FRAMING_CHECK_EN
    localparam bit FRAMING = 1'b1;
`else
    localparam bit FRAMING = 1'b0;
`endif

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         cycle;
    } expEntry_t;

    logic       clk = 1'b0;
    logic       rstA, rstB, rxA, rxB;
    logic [7:0] dataA, dataB;
    logic       validA, validB, ferrA, ferrB, busyA, busyB;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    expEntry_t  qA[$];
    expEntry_t  qB[$];
    expEntry_t  popA, popB;

    uart_rx #(.BAUD(BAUD_A)) dutA (
        .clk(clk), .rst(rstA), .rx(rxA), .data(dataA),
        .valid(validA), .ferr(ferrA), .busy(busyA)
    );

    uart_rx #(.BAUD(BAUD_B)) dutB (
        .clk(clk), .rst(rstB), .rx(rxB), .data(dataB),
        .valid(validB), .ferr(ferrB), .busy(busyB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives the first nPeriods bit periods of a frame; optionally queues its strobe.
    task automatic applyStimulus(input bit useB, input logic [7:0] b, input bit stopBit,
                                 input int nPeriods, input bit expectStrobe);
        int        bw    = useB ? BAUD_B : BAUD_A;
        logic [9:0] frame = {stopBit, b, 1'b0};
        int        t0    = cyc + 1;
        expEntry_t e;
        if (expectStrobe) begin
            e.isErr = !stopBit && FRAMING;
            e.data  = b;
            e.cycle = t0 + 2 + bw / 2 + 9 * bw;
            if (useB) qB.push_back(e);
            else      qA.push_back(e);
        end
        for (int i = 0; i < nPeriods; i++) begin
            if (useB) rxB = frame[i];
            else      rxA = frame[i];
            repeat (bw) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gotoCycle(input int k);
        @(negedge clk);
        while (cyc < k) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (validA === 1'b1 || ferrA === 1'b1) begin
            checkOutput("strobeExclusiveA", {31'b0, validA & ferrA}, 32'd0);
            if (qA.size() == 0) begin
                checkOutput("unexpectedStrobeA", {30'b0, validA, ferrA}, 32'd0);
            end else begin
                popA = qA.pop_front();
                checkOutput("strobeKindA", {31'b0, ferrA}, {31'b0, popA.isErr});
                if (!popA.isErr) checkOutput("dataA", {24'b0, dataA}, {24'b0, popA.data});
                checkOutput("strobeCycleA", cyc, popA.cycle);
            end
        end
    end

    always @(negedge clk) begin
        if (validB === 1'b1 || ferrB === 1'b1) begin
            checkOutput("strobeExclusiveB", {31'b0, validB & ferrB}, 32'd0);
            if (qB.size() == 0) begin
                checkOutput("unexpectedStrobeB", {30'b0, validB, ferrB}, 32'd0);
            end else begin
                popB = qB.pop_front();
                checkOutput("strobeKindB", {31'b0, ferrB}, {31'b0, popB.isErr});
                if (!popB.isErr) checkOutput("dataB", {24'b0, dataB}, {24'b0, popB.data});
                checkOutput("strobeCycleB", cyc, popB.cycle);
            end
        end
    end

    initial begin
        int t0;
        rxA  = 1'b1;
        rxB  = 1'b1;
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetDataA",  {24'b0, dataA}, 32'd0);
        checkOutput("resetValidA", {31'b0, validA}, 32'd0);
        checkOutput("resetFerrA",  {31'b0, ferrA}, 32'd0);
        checkOutput("resetBusyA",  {31'b0, busyA}, 32'd0);
        checkOutput("resetDataB",  {24'b0, dataB}, 32'd0);
        checkOutput("resetValidB", {31'b0, validB}, 32'd0);
        checkOutput("resetFerrB",  {31'b0, ferrB}, 32'd0);
        checkOutput("resetBusyB",  {31'b0, busyB}, 32'd0);
        @(posedge clk);
        #1;
        rstA = 1'b0;
        rstB = 1'b0;
        idle(4);

        // Single good frame.
        applyStimulus(1'b0, 8'h55, 1'b1, 10, 1'b1);
        idle(16);
        checkOutput("dataHold55", {24'b0, dataA}, 32'h55);

        // Start-bit glitch: three low cycles only.
        t0  = cyc + 1;
        rxA = 1'b0;
        idle(3);
        rxA = 1'b1;
        gotoCycle(t0 + 2);
        checkOutput("glitchBusyRise", {31'b0, busyA}, 32'd1);
        gotoCycle(t0 + 5);
        checkOutput("glitchBusyHeld", {31'b0, busyA}, 32'd1);
        gotoCycle(t0 + 6);
        checkOutput("glitchBusyFall", {31'b0, busyA}, 32'd0);
        @(posedge clk);
        #1;
        idle(16);
        checkOutput("glitchDataHold", {24'b0, dataA}, 32'h55);

        // Back-to-back frames with no idle gap.
        applyStimulus(1'b0, 8'hA3, 1'b1, 10, 1'b1);
        applyStimulus(1'b0, 8'h0F, 1'b1, 10, 1'b1);
        idle(16);
        checkOutput("dataAfterB2B", {24'b0, dataA}, 32'h0F);

        // Bad stop bit followed by a held-low line.
        applyStimulus(1'b0, 8'h81, 1'b0, 10, 1'b1);
        idle(30);
        checkOutput("busyInBreak", {31'b0, busyA}, 32'd1);
        rxA = 1'b1;
        idle(4);
        checkOutput("busyAfterBreak", {31'b0, busyA}, 32'd0);
        checkOutput("dataAfterFerr", {24'b0, dataA}, FRAMING ? 32'h0F : 32'h81);
        idle(16);

        // Reset during bit 4 of 0xC6, then a clean 0x3C.
        applyStimulus(1'b0, 8'hC6, 1'b1, 5, 1'b0);
        rxA = 1'b0;
        idle(4);
        rstA = 1'b1;
        idle(1);
        rstA = 1'b0;
        rxA  = 1'b1;
        checkOutput("midResetBusy", {31'b0, busyA}, 32'd0);
        checkOutput("midResetData", {24'b0, dataA}, 32'd0);
        idle(16);
        applyStimulus(1'b0, 8'h3C, 1'b1, 10, 1'b1);
        idle(16);
        checkOutput("dataAfterReset", {24'b0, dataA}, 32'h3C);

        // Full-rate divisor: all-zeros and all-ones bytes.
        idle(20);
        applyStimulus(1'b1, 8'h00, 1'b1, 10, 1'b1);
        idle(200);
        applyStimulus(1'b1, 8'hFF, 1'b1, 10, 1'b1);
        idle(200);
        checkOutput("dataHoldFF", {24'b0, dataB}, 32'hFF);

        checkOutput("pendingA", qA.size(), 32'd0);
        checkOutput("pendingB", qB.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
